fb_scanout: RTL and testbench
=============================

# fb_scanout

Scan-out stage for the 640x480 console framebuffer in the fbclk domain. Sits downstream of the frame DMA read controller: pulls 64-bit words from its show-ahead FIFO, unpacks two 24-bit pixels per word and drives registered RGB, DE, HS and VS toward the DVI DDR output flops. Owns the video timing counters, start-up gating and underflow accounting, so the DVI pin stage only has to register and DDR the outputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, active level of hs/vs (0 = active-low)
- UF_COLOR, 24'hff00ff, {R,G,B} driven for a pixel whose word was not ready

- fbclk  input  1  pixel clock, 25 MHz
- fbclk_rst_b  input  1  reset for fbclk, asynchronous, active-low
- fifo_empty  input  1  DMA FIFO empty; may originate in another domain
- data  input  64  FIFO head word, show-ahead; pixel0 = [31:8], pixel1 = [63:40] (R,G,B MSB first), [7:0] and [39:32] ignored
- data_ready  input  1  data holds a valid head word
- request  output  1  single-cycle pop of the FIFO head word
- red, green, blue  output  8 each  pixel colour, 0 when de low
- de  output  1  active-video enable
- hs, vs  output  1 each  syncs, polarity per SYNC_POL
- frame_start  output  1  one-cycle pulse with the first active pixel of each frame
- underflow  output  1  sticky flag, cleared only by reset
- underflow_count  output  16  count of starved active pixels, saturating at 16'hffff

## Operation
- fifo_empty passes through a 2-flop synchroniser (reset value 1) before use.
- State machine:
  - IDLE (reset): counters held at h = 0, v = 0. Outputs are held at reset values. Go to PRIME when the synchronised fifo_empty is 0.
  - PRIME: one cycle. Go to RUN.
  - RUN: counters free-run. Stays in RUN until reset; a later fifo_empty never returns the block to IDLE.
- Counters:
  - h counts 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 (799). At the top value it wraps to 0 and increments v.
  - v counts 0..V_ACTIVE+V_FP+V_SYNC+V_BP-1 (524) and wraps to 0.
  - Both counters are 11 bits wide.
- Timing decode:
  - active = h < H_ACTIVE and v < V_ACTIVE.
  - hs is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vs is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
- Unpacking: a 1-bit offset selects which pixel of the head word is shown; 0 selects pixel0. On an active cycle with data_ready = 1:
  - offset 0: show pixel0, then offset becomes 1.
  - offset 1: show pixel1, assert request for that cycle, then offset becomes 0.
- Underflow: on an active cycle with data_ready = 0:
  - show UF_COLOR;
  - do not assert request and leave offset unchanged;
  - set underflow and increment underflow_count.
- Blanking: offset holds, request = 0, and RGB is 0.
- request is combinational from the registered state, so the pop lands on the same edge that registers pixel1.

## Timing
- Reset values: request 0, red/green/blue 0, de 0, frame_start 0, underflow 0, underflow_count 0, offset 0, state IDLE. hs and vs reset to their inactive level (~SYNC_POL).
- Start-up latency: fifo_empty falls at edge N. The synchronised value is 0 after edge N+2, PRIME is entered at edge N+3, RUN at edge N+4. The first RUN cycle has h = 0, v = 0.
- Output latency: every output except request is registered one cycle after the h/v/offset values that produce it. hs, vs, de and RGB therefore stay mutually aligned.
- frame_start is high in the same cycle as de for pixel (0,0).
- Requests: one per two displayed pixels, so 320 per line and 153600 per frame when never starved.
- Reset mid-frame: all state, counters and outputs return to reset values immediately (asynchronous). The next start requires the FIFO to be non-empty again.

## Test plan
- Reset, then fifo_empty = 0 at edge 10: state reaches RUN at edge 14; first de = 1 and frame_start = 1 one cycle later; hs/vs held inactive (1) until then.
- Constant word 64'h11223300_AABBCC00, data_ready = 1: RGB alternates AA,BB,CC / 11,22,33 every cycle; request pulses on every second active cycle; 320 pulses per line.
- Full frame: de high 640 of every 800 cycles on 480 of 525 lines; hs low for h 656..751; vs low for lines 490..491; frame period 420000 cycles.
- data_ready = 0 for 3 active cycles at offset 1: three pixels of ff00ff, no request, offset still 1; underflow = 1, underflow_count = 3; pixel1 is shown when data_ready returns.
- Assert fbclk_rst_b low at h = 300, v = 200: all outputs return to reset values immediately; after release the block stays IDLE until fifo_empty is seen at 0.
- Force 70000 starved pixels: underflow_count saturates at 16'hffff.

Source files
------------

// File: rtl/fb_scanout.sv
// Video scan-out for the console framebuffer: pops 64-bit words from the DMA FIFO,
// unpacks two 24-bit pixels per word and drives registered RGB/DE/HS/VS.
module fb_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter logic [23:0] UF_COLOR = 24'hff00ff
) (
  input  logic        fbclk,
  input  logic        fbclk_rst_b,
  input  logic        fifo_empty,
  input  logic [63:0] data,
  input  logic        data_ready,
  output logic        request,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

  state_e      state_q, state_d;
  logic        empty_meta_q, empty_meta_d;
  logic        empty_sync_q, empty_sync_d;
  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        offset_q, offset_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        frame_start_q, frame_start_d;
  logic        underflow_q, underflow_d;
  logic [15:0] uf_count_q, uf_count_d;

  logic        run;
  logic        active;
  logic [23:0] pixel;
  logic        unused_pad_bits;

  assign run    = (state_q == ST_RUN);
  assign active = run && (h_q < H_ACT) && (v_q < V_ACT);
  assign pixel  = offset_q ? data[63:40] : data[31:8];
  assign unused_pad_bits = ^{data[39:32], data[7:0]};

  // The pop is combinational so it lands on the same edge that registers pixel1.
  assign request = active && data_ready && offset_q;

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch can leave a variable unassigned
    // and infer a latch.
    state_d       = state_q;
    empty_meta_d  = fifo_empty;
    empty_sync_d  = empty_meta_q;
    h_d           = h_q;
    v_d           = v_q;
    offset_d      = offset_q;
    rgb_d         = rgb_q;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    frame_start_d = frame_start_q;
    underflow_d   = underflow_q;
    uf_count_d    = uf_count_q;

    case (state_q)
      ST_IDLE:  if (!empty_sync_q) state_d = ST_PRIME;
      ST_PRIME: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    // Outside RUN every output simply holds its reset value.
    if (run) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end

      de_d          = active;
      hs_d          = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_d          = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = active && (h_q == '0) && (v_q == '0);
      rgb_d         = '0;

      if (active) begin
        if (data_ready) begin
          rgb_d    = pixel;
          offset_d = ~offset_q;
        end else begin
          // Starved pixel: keep the offset so the same pixel is shown once data returns.
          rgb_d       = UF_COLOR;
          underflow_d = 1'b1;
          if (uf_count_q != 16'hffff) uf_count_d = uf_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      state_q       <= ST_IDLE;
      empty_meta_q  <= 1'b1;
      empty_sync_q  <= 1'b1;
      h_q           <= '0;
      v_q           <= '0;
      offset_q      <= 1'b0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      uf_count_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q       <= state_d;
      empty_meta_q  <= empty_meta_d;
      empty_sync_q  <= empty_sync_d;
      h_q           <= h_d;
      v_q           <= v_d;
      offset_q      <= offset_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      uf_count_q    <= uf_count_d;
    end
  end

  assign red             = rgb_q[23:16];
  assign green           = rgb_q[15:8];
  assign blue            = rgb_q[7:0];
  assign de              = de_q;
  assign hs              = hs_q;
  assign vs              = vs_q;
  assign frame_start     = frame_start_q;
  assign underflow       = underflow_q;
  assign underflow_count = uf_count_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout with a reduced raster so whole frames and
// counter saturation fit in a short run; a cycle-level behavioural model is compared every cycle.
module tb_fb_scanout;

  localparam int HA = 200, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 100, VF = 1, VSW = 2, VB = 1;
  localparam int H_TOT = HA + HF + HSW + HB;   // 204
  localparam int V_TOT = VA + VF + VSW + VB;   // 104
  localparam logic [23:0] UF = 24'hff00ff;

  logic        fbclk = 1'b0;
  logic        fbclk_rst_b = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [63:0] data = '0;
  logic        data_ready = 1'b0;
  logic        request, de, hs, vs, frame_start, underflow;
  logic [7:0]  red, green, blue;
  logic [15:0] underflow_count;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(1'b0), .UF_COLOR(UF)
  ) dut (
    .fbclk(fbclk), .fbclk_rst_b(fbclk_rst_b), .fifo_empty(fifo_empty),
    .data(data), .data_ready(data_ready), .request(request),
    .red(red), .green(green), .blue(blue), .de(de), .hs(hs), .vs(vs),
    .frame_start(frame_start), .underflow(underflow), .underflow_count(underflow_count)
  );

  always #20 fbclk = ~fbclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: start-up phase, elapsed RUN cycles, pixel offset, underflow tally.
  int          m_mode = 0;      // 0 waiting, 1 priming, 2 running
  int          m_t    = 0;      // RUN cycles elapsed
  bit          m_e1 = 1'b1, m_e2 = 1'b1;
  bit          m_off = 1'b0, m_uf = 1'b0;
  int          m_cnt = 0;
  logic [23:0] e_rgb = '0;
  bit          e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;

  function automatic int cur_h();
    return m_t % H_TOT;
  endfunction
  function automatic int cur_v();
    return (m_t / H_TOT) % V_TOT;
  endfunction
  function automatic bit cur_active();
    return m_mode == 2 && cur_h() < HA && cur_v() < VA;
  endfunction

  always @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      m_e1 <= 1'b1; m_e2 <= 1'b1; m_mode <= 0; m_t <= 0;
      m_off <= 1'b0; m_uf <= 1'b0; m_cnt <= 0;
      e_rgb <= '0; e_de <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
    end else begin
      m_e1 <= fifo_empty;
      m_e2 <= m_e1;
      if (m_mode == 0 && !m_e2) m_mode <= 1;
      else if (m_mode == 1) m_mode <= 2;
      if (m_mode == 2) begin
        e_de <= cur_active();
        e_hs <= !(cur_h() >= HA + HF && cur_h() < HA + HF + HSW);
        e_vs <= !(cur_v() >= VA + VF && cur_v() < VA + VF + VSW);
        e_fs <= cur_active() && cur_h() == 0 && cur_v() == 0;
        if (cur_active()) begin
          if (data_ready) begin
            e_rgb <= m_off ? data[63:40] : data[31:8];
            m_off <= !m_off;
          end else begin
            e_rgb <= UF;
            m_uf  <= 1'b1;
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
          end
        end else begin
          e_rgb <= '0;
        end
        m_t <= m_t + 1;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge fbclk) begin
    check("rgb",         32'({red, green, blue}), 32'(e_rgb));
    check("de",          32'(de),               32'(e_de));
    check("hs",          32'(hs),               32'(e_hs));
    check("vs",          32'(vs),               32'(e_vs));
    check("frame_start", 32'(frame_start),      32'(e_fs));
    check("underflow",   32'(underflow),        32'(m_uf));
    check("uf_count",    32'(underflow_count),  32'(m_cnt));
    check("request",     32'(request),          32'(cur_active() && data_ready && m_off));
  end

  initial begin
    int e, cnt, last_fs, period;
    bit ok;

    repeat (3) @(posedge fbclk);
    #1 fbclk_rst_b = 1'b1;
    data = 64'h11223300_AABBCC00;
    data_ready = 1'b1;

    // Start-up: FIFO goes non-empty after edge 10, first de expected after edge 15.
    e = 0;
    while (de !== 1'b1 && e < 40) begin
      @(posedge fbclk); e++; #1;
      if (e == 10) fifo_empty = 1'b0;
    end
    check("first_de_edge", 32'(e), 32'd15);
    check("first_frame_start", 32'(frame_start), 32'd1);
    check("first_pixel0", 32'({red, green, blue}), 32'h00AABBCC);
    @(posedge fbclk); #1;
    check("first_pixel1", 32'({red, green, blue}), 32'h00112233);

    // One full line of requests with a constant word.
    cnt = 0;
    repeat (H_TOT) begin
      @(negedge fbclk);
      if (request) cnt++;
      @(posedge fbclk); #1;
    end
    check("requests_per_line", 32'(cnt), 32'd100);

    // Three starved pixels while pixel1 is pending.
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge fbclk); #1;
      if (cur_active() && cur_h() >= 10 && cur_h() < 100 && m_off) ok = 1'b1;
    end
    check("uf_window_found", 32'(ok), 32'd1);
    data_ready = 1'b0;
    repeat (3) begin @(posedge fbclk); #1; end
    check("uf_rgb", 32'({red, green, blue}), 32'h00ff00ff);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_count_3", 32'(underflow_count), 32'd3);
    data_ready = 1'b1;
    @(negedge fbclk);
    check("uf_resume_request", 32'(request), 32'd1);
    @(posedge fbclk); #1;
    check("uf_resume_pixel1", 32'({red, green, blue}), 32'h00112233);

    // Random traffic, then reset mid-frame at h=150, v=20.
    ok = 1'b0;
    for (int i = 0; i < 10000 && !ok; i++) begin
      @(posedge fbclk); #1;
      if (cur_h() == 150 && cur_v() == 20) ok = 1'b1;
      else begin
        data       = {$urandom, $urandom};
        data_ready = ($urandom_range(0, 3) != 0);
        fifo_empty = 1'($urandom_range(0, 1));
      end
    end
    check("reset_point_found", 32'(ok), 32'd1);
    #5 fbclk_rst_b = 1'b0;
    fifo_empty = 1'b1;
    #1;
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_request", 32'(request), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_uf_count", 32'(underflow_count), 32'd0);
    repeat (3) @(posedge fbclk);
    #1 fbclk_rst_b = 1'b1;

    cnt = 0;
    repeat (20) begin
      @(posedge fbclk); #1;
      if (de) cnt++;
    end
    check("idle_after_reset_de", 32'(cnt), 32'd0);

    // Restart and run random traffic.
    fifo_empty = 1'b0;
    repeat (10) begin @(posedge fbclk); #1; end
    repeat (1500) begin
      @(posedge fbclk); #1;
      data       = {$urandom, $urandom};
      data_ready = ($urandom_range(0, 3) != 0);
      fifo_empty = 1'($urandom_range(0, 1));
    end

    // Starve until the counter saturates; measure the frame period on the way.
    data_ready = 1'b0;
    e = 0; last_fs = -1; period = 0;
    while (m_cnt < 65535 && e < 80000) begin
      @(negedge fbclk);
      if (frame_start) begin
        if (last_fs >= 0 && period == 0) period = e - last_fs;
        last_fs = e;
      end
      @(posedge fbclk); #1;
      e++;
    end
    check("saturation_reached_in_budget", 32'(e < 80000), 32'd1);
    check("frame_period", 32'(period), 32'd21216);
    repeat (50) begin @(posedge fbclk); #1; end
    check("uf_count_saturated", 32'(underflow_count), 32'h0000ffff);
    check("uf_sticky", 32'(underflow), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
